// File: rtl/fetch_redirect_pkg.sv
// Shared types, constants and the ROB age helper for the fetch redirect controller.
package fetch_redirect_pkg;

    localparam int NUM_RES_PORTS = 4;
    localparam int RES_IDX_W     = $clog2(NUM_RES_PORTS);
    localparam int TAG_W_MAX     = 16;

    typedef logic [0:0] state_t;
    localparam state_t IDLE = 1'b0;
    localparam state_t HOLD = 1'b1;

    // Distance of a tag from the ROB head, modulo 2^tag_w; smaller means older.
    function automatic logic [TAG_W_MAX-1:0] rob_age(
        input logic [TAG_W_MAX-1:0] tag,
        input logic [TAG_W_MAX-1:0] head,
        input int                   tag_w
    );
        logic [TAG_W_MAX-1:0] mask;
        mask = (TAG_W_MAX'(1) << tag_w) - TAG_W_MAX'(1);
        return (tag - head) & mask;
    endfunction

endpackage

// File: rtl/fetch_redirect_ctrl_oldest_sel.sv
// Combinational 4-way selector: oldest candidate relative to the ROB head, lowest port on ties.
module redirect_oldest_sel
    import fetch_redirect_pkg::*;
#(
    parameter int size  = 32,
    parameter int TAG_W = 6
) (
    input  logic [TAG_W-1:0]         rob_head,
    input  logic [NUM_RES_PORTS-1:0] cand,
    input  logic [TAG_W-1:0]         tags    [NUM_RES_PORTS],
    input  logic [size-1:0]          targets [NUM_RES_PORTS],
    output logic                     found,
    output logic [RES_IDX_W-1:0]     index,
    output logic [TAG_W-1:0]         tag,
    output logic [size-1:0]          target
);

    logic [TAG_W-1:0] best_age;
    logic [TAG_W-1:0] age_i;

    always_comb begin
        found    = 1'b0;
        index    = '0;
        best_age = '0;
        age_i    = '0;
        for (int i = 0; i < NUM_RES_PORTS; i++) begin
            age_i = TAG_W'(rob_age(TAG_W_MAX'(tags[i]), TAG_W_MAX'(rob_head), TAG_W));
            // strict compare keeps the lower port on equal age
            if (cand[i] && (!found || age_i < best_age)) begin
                found    = 1'b1;
                index    = RES_IDX_W'(i);
                best_age = age_i;
            end
        end
    end

    assign tag    = tags[index];
    assign target = targets[index];

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Redirect arbiter: flushes on the oldest mispredict, then holds a fetch bubble for HOLD_CYCLES.
// Define REDIRECT_STATS_EN to add saturating redirect/preempt/drop counters.
//
// state | meaning
// IDLE  | no redirect in progress, any winner flushes next cycle
// HOLD  | bubble window after a flush, only strictly older winners preempt
module fetch_redirect_ctrl
    import fetch_redirect_pkg::*;
#(
    parameter int size        = 32,
    parameter int TAG_W       = 6,
    parameter int HOLD_CYCLES = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [TAG_W-1:0]         rob_head_i,
    input  logic [NUM_RES_PORTS-1:0] res_valid_i,
    input  logic [NUM_RES_PORTS-1:0] res_mispredict_i,
    input  logic [TAG_W-1:0]         res_tag_i_0,
    input  logic [TAG_W-1:0]         res_tag_i_1,
    input  logic [TAG_W-1:0]         res_tag_i_2,
    input  logic [TAG_W-1:0]         res_tag_i_3,
    input  logic [size-1:0]          res_target_i_0,
    input  logic [size-1:0]          res_target_i_1,
    input  logic [size-1:0]          res_target_i_2,
    input  logic [size-1:0]          res_target_i_3,
    output logic                     flush_o,
    output logic [size-1:0]          correct_pc_o,
    output logic [TAG_W-1:0]         flush_tag_o,
    output logic                     buble_o,
    output logic                     busy_o
`ifdef REDIRECT_STATS_EN
   ,output logic [31:0]              redirect_cnt_o,
    output logic [31:0]              preempt_cnt_o,
    output logic [31:0]              drop_cnt_o
`endif
);

    localparam int CNT_W = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES);

    state_t                   state, state_d;
    logic [CNT_W-1:0]         cnt, cnt_d;
    logic [NUM_RES_PORTS-1:0] cand;
    logic [TAG_W-1:0]         tag_arr [NUM_RES_PORTS];
    logic [size-1:0]          tgt_arr [NUM_RES_PORTS];
    logic                     sel_found;
    logic [RES_IDX_W-1:0]     sel_index;
    logic [TAG_W-1:0]         sel_tag;
    logic [size-1:0]          sel_target;
    logic [TAG_W-1:0]         win_age, cur_age;
    logic                     preempt, drop, issue;

    assign cand       = res_valid_i & res_mispredict_i;
    assign tag_arr[0] = res_tag_i_0;
    assign tag_arr[1] = res_tag_i_1;
    assign tag_arr[2] = res_tag_i_2;
    assign tag_arr[3] = res_tag_i_3;
    assign tgt_arr[0] = res_target_i_0;
    assign tgt_arr[1] = res_target_i_1;
    assign tgt_arr[2] = res_target_i_2;
    assign tgt_arr[3] = res_target_i_3;

    redirect_oldest_sel #(.size(size), .TAG_W(TAG_W)) u_sel (
        .rob_head (rob_head_i),
        .cand     (cand),
        .tags     (tag_arr),
        .targets  (tgt_arr),
        .found    (sel_found),
        .index    (sel_index),
        .tag      (sel_tag),
        .target   (sel_target)
    );

    always_comb begin
        if (sel_found) assert (cand[sel_index]);
    end

    // Both ages use this cycle's head, so a moving head never reorders the compare.
    assign win_age = TAG_W'(rob_age(TAG_W_MAX'(sel_tag), TAG_W_MAX'(rob_head_i), TAG_W));
    assign cur_age = TAG_W'(rob_age(TAG_W_MAX'(flush_tag_o), TAG_W_MAX'(rob_head_i), TAG_W));

    assign preempt = (state == HOLD) && sel_found && (win_age < cur_age);
    assign drop    = (state == HOLD) && sel_found && !preempt;
    assign issue   = ((state == IDLE) && sel_found) || preempt;

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        if (issue) begin
            cnt_d   = HOLD_LOAD;
            state_d = (HOLD_CYCLES == 0) ? IDLE : HOLD;
        end else if (state == HOLD) begin
            if (cnt <= CNT_W'(1)) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            cnt          <= '0;
            flush_o      <= 1'b0;
            correct_pc_o <= '0;
            flush_tag_o  <= '0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            flush_o <= issue;
            if (issue) begin
                correct_pc_o <= sel_target;
                flush_tag_o  <= sel_tag;
            end
        end
    end

    assign buble_o = (state == HOLD);
    assign busy_o  = (state != IDLE);

`ifdef REDIRECT_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            redirect_cnt_o <= '0;
            preempt_cnt_o  <= '0;
            drop_cnt_o     <= '0;
        end else begin
            if (issue && redirect_cnt_o != '1)  redirect_cnt_o <= redirect_cnt_o + 32'd1;
            if (preempt && preempt_cnt_o != '1) preempt_cnt_o  <= preempt_cnt_o + 32'd1;
            if (drop && drop_cnt_o != '1)       drop_cnt_o     <= drop_cnt_o + 32'd1;
        end
    end
`endif

endmodule
